// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the MIPS program-counter fetch stage:
// FSM state encodings, address widths, reset PC default and branch displacement helper.
package pc_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Encodings are visible on the state_o port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  // Sign-extend a branch immediate and turn it into a byte displacement.
  function automatic logic [ADDR_W-1:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Priority is jr > j/jal > taken branch > sequential, and the chosen target is
// classified as misaligned or beyond the end of instruction memory.
module pc_fetch_unit_next_pc_logic
  import pc_fetch_unit_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_taken_i,
  input  logic [15:0]       branch_offset_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic              jump_reg_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              misaligned_o,
  output logic              out_of_range_o
);

  // One extra bit so the byte limit itself is representable for any depth.
  localparam logic [ADDR_W:0] MemLimit = 33'(MEM_WORDS) << 2;

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;

  assign pc_plus4_o    = pc_i + 32'd4;
  assign jump_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};
  assign branch_target = pc_plus4_o + branch_disp(branch_offset_i);

  // Highest-priority redirect wins; simultaneous selects are not an error.
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_reg_i) begin
      next_pc_o = jr_target_i;
    end else if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target;
    end
  end

  assign misaligned_o   = |next_pc_o[1:0];
  assign out_of_range_o = ({1'b0, next_pc_o} >= MemLimit);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding the instruction memory of the single-cycle MIPS core.
// Holds the PC, runs the RUN/STALL/HALT state machine and counts PC advances.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_WORDS = 256,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [15:0]        branch_offset_i,
  input  logic               jump_i,
  input  logic [25:0]        jump_index_i,
  input  logic               jump_reg_i,
  input  logic [31:0]        jr_target_i,
  output logic [31:0]        instr_addr_o,
  output logic [31:0]        pc_plus4_o,
  output logic [1:0]         state_o,
  output logic               halted_o,
  output logic               misalign_err_o,
  output logic [COUNT_W-1:0] fetch_count_o
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic [31:0] next_pc;
  logic        misaligned;
  logic        out_of_range;

  pc_fetch_unit_next_pc_logic #(
    .MEM_WORDS(MEM_WORDS)
  ) u_next_pc (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken_i),
    .branch_offset_i(branch_offset_i),
    .jump_i         (jump_i),
    .jump_index_i   (jump_index_i),
    .jump_reg_i     (jump_reg_i),
    .jr_target_i    (jr_target_i),
    .next_pc_o      (next_pc),
    .pc_plus4_o     (pc_plus4_o),
    .misaligned_o   (misaligned),
    .out_of_range_o (out_of_range)
  );

  // Next state: stall beats everything, halt checks beat resumption, HALT is terminal.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (stall_i) begin
          state_d = ST_STALL;
        end else if (misaligned) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else if (out_of_range) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
          pc_d    = next_pc;
          if (count_q != '1) begin
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State registers with synchronous reset that overrides stall and halt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign instr_addr_o   = pc_q;
  assign state_o        = state_q;
  assign halted_o       = (state_q == ST_HALT);
  assign misalign_err_o = err_q;
  assign fetch_count_o  = count_q;

endmodule
